// File: rtl/ser_pkg.sv
// Shared definitions for the serial write transmitter.
// Holds the FSM state encoding, the bus window decode constants, the
// register offsets inside the window, the status bit positions and a
// small helper for the window decode.
package ser_pkg;

  localparam int unsigned BA_W   = 10;  // bus address bits BA13..BA4
  localparam int unsigned STAT_W = 8;
  localparam int unsigned CNT_W  = 8;   // bit timer width, covers DIV up to 255

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  // Window decode: BA13 must be 0 and BA12 must be 1
  localparam logic WIN_BA13 = 1'b0;
  localparam logic WIN_BA12 = 1'b1;

  // Register offsets on ba[7:4]
  localparam logic [3:0] OFF_DATA = 4'h2;
  localparam logic [3:0] OFF_STAT = 4'h1;

  // Status bit positions
  localparam int unsigned STAT_OVR  = 7;
  localparam int unsigned STAT_HOLD = 6;
  localparam int unsigned STAT_BUSY = 5;

  // True when the active-low select and the two window address bits match
  function automatic logic win_hit(input logic ser_n, input logic ba13, input logic ba12);
    return ~ser_n & (ba13 == WIN_BA13) & (ba12 == WIN_BA12);
  endfunction

endpackage

// File: rtl/ser_wr_tx_if.sv
// Bus-side interface of the serial write transmitter.
// ser_n : active-low serial-port select
// ba    : address bits BA13..BA4
// br_w  : 1 = read, 0 = write
// bd    : write data
// stat  : status returned to the bus {ovr, hold_full, busy, 5'b0}
interface ser_wr_tx_if #(
  parameter int unsigned NBITS = 8
);

  logic             ser_n;
  logic [13:4]      ba;
  logic             br_w;
  logic [NBITS-1:0] bd;
  logic [7:0]       stat;

  modport master (
    output ser_n,
    output ba,
    output br_w,
    output bd,
    input  stat
  );

  modport slave (
    input  ser_n,
    input  ba,
    input  br_w,
    input  bd,
    output stat
  );

endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period timer: a DIV-cycle down-counter.
// clk, rst_n  : clock and async active-low reset
// run         : count while high, wrapping from 0 back to DIV-1
// reload      : force the count to DIV-1 (start of a new frame)
// tick_c      : high in the last cycle of each bit period
// pre_tick_c  : high in the cycle before tick_c
module ser_bit_timer
  import ser_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic reload,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload wins, otherwise count down and wrap
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD_VAL;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c     = run & (cnt_q == '0);
  assign pre_tick_c = run & (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ser_wr_tx.sv
// Serial write transmitter with a one-entry holding register.
// Bus writes to the DATA offset queue a byte; the byte is sent as
// start(0), NBITS data bits LSB-first, stop(1), each bit DIV clocks.
// A status read returns {ovr, hold_full, busy, 5'b0} and clears ovr.
// clk, rst_n : clock and async active-low reset
// bus        : bus-side interface (slave modport)
// sdwr       : serial data out, idles high
// done       : one-cycle pulse in the last cycle of each stop bit
module ser_wr_tx
  import ser_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned NBITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  ser_wr_tx_if.slave  bus,
  output logic        sdwr,
  output logic        done
);

  localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);

  ser_state_e       state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ovr_q, ovr_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sdwr_q, sdwr_d;
  logic             done_q, done_d;
  logic             wr_dec_q, rd_dec_q;

  logic win_c, wr_dec_c, rd_dec_c, wr_acc_c, rd_acc_c;
  logic busy_c, tick_c, pre_tick_c, reload_c;
  logic frame_end_c, start_new_c, drop_c, load_hold_c;
  logic [STAT_W-1:0] stat_c;
  logic unused_ba;

  // Address bits BA11..BA8 take no part in the decode
  assign unused_ba = ^bus.ba[11:8];

  // Bus decode; each access acts only on the rising edge of its decode
  always_comb begin
    win_c    = win_hit(bus.ser_n, bus.ba[13], bus.ba[12]);
    wr_dec_c = win_c & ~bus.br_w & (bus.ba[7:4] == OFF_DATA);
    rd_dec_c = win_c &  bus.br_w & (bus.ba[7:4] == OFF_STAT);
    wr_acc_c = wr_dec_c & ~wr_dec_q;
    rd_acc_c = rd_dec_c & ~rd_dec_q;
  end

  assign busy_c = (state_q != S_IDLE);

  ser_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (busy_c),
    .reload     (reload_c),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // A write landing on the final stop edge with nothing held starts the next frame
  // directly, exactly as it would from IDLE.
  always_comb begin
    frame_end_c = (state_q == S_STOP) & tick_c;
    start_new_c = wr_acc_c & ~hold_full_q &
                  ((state_q == S_IDLE) | frame_end_c);
    drop_c      = wr_acc_c & hold_full_q;
    load_hold_c = wr_acc_c & ~hold_full_q & busy_c & ~start_new_c;
  end

  // Next-state, datapath and holding-register logic
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    bit_cnt_d   = bit_cnt_q;
    sdwr_d      = sdwr_q;
    done_d      = 1'b0;
    reload_c    = 1'b0;

    if (load_hold_c) begin
      hold_d      = bus.bd;
      hold_full_d = 1'b1;
    end

    // A drop on the same edge as a status read keeps ovr set
    if (drop_c) begin
      ovr_d = 1'b1;
    end else if (rd_acc_c) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d     = S_START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          sdwr_d      = 1'b0;
          reload_c    = 1'b1;
        end else if (start_new_c) begin
          state_d  = S_START;
          shift_d  = bus.bd;
          sdwr_d   = 1'b0;
          reload_c = 1'b1;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          sdwr_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_STOP;
            sdwr_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
            sdwr_d    = shift_d[0];
          end
        end
      end
      S_STOP: begin
        // Registered done lands in the final stop cycle
        if (pre_tick_c) begin
          done_d = 1'b1;
        end
        if (tick_c) begin
          bit_cnt_d = '0;
          if (hold_full_q) begin
            state_d     = S_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            sdwr_d      = 1'b0;
          end else if (start_new_c) begin
            state_d = S_START;
            shift_d = bus.bd;
            sdwr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sdwr_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      bit_cnt_q   <= '0;
      sdwr_q      <= 1'b1;
      done_q      <= 1'b0;
      wr_dec_q    <= 1'b0;
      rd_dec_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      bit_cnt_q   <= bit_cnt_d;
      sdwr_q      <= sdwr_d;
      done_q      <= done_d;
      wr_dec_q    <= wr_dec_c;
      rd_dec_q    <= rd_dec_c;
    end
  end

  // Status is a direct view of registered state
  always_comb begin
    stat_c            = '0;
    stat_c[STAT_OVR]  = ovr_q;
    stat_c[STAT_HOLD] = hold_full_q;
    stat_c[STAT_BUSY] = busy_c;
  end

  assign bus.stat = stat_c;
  assign sdwr     = sdwr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ser_wr_tx.sv
// Directed bench for ser_wr_tx with DIV=4, NBITS=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ser_wr_tx;

  logic clk;
  logic rst_n;
  logic sdwr;
  logic done;

  int n_cmp = 0;
  int n_err = 0;

  ser_wr_tx_if #(.NBITS(8)) bus ();

  ser_wr_tx #(
    .DIV   (4),
    .NBITS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sdwr  (sdwr),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level in frame cycle k (1-based) for nfr back-to-back frames
  function automatic logic exp_sdwr(input int k, input logic [7:0] d0,
                                    input logic [7:0] d1, input int nfr);
    int f, j, b;
    logic [7:0] d;
    if (k < 1 || k > 40 * nfr) return 1'b1;
    f = (k - 1) / 40;
    j = (k - 1) % 40;
    b = j / 4;
    d = (f == 0) ? d0 : d1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic step_chk(input int k, input logic [7:0] d0, input logic [7:0] d1, input int nfr);
    logic in_frame;
    in_frame = (k >= 1) && (k <= 40 * nfr);
    chk($sformatf("sdwr k=%0d", k), 32'(sdwr), 32'(exp_sdwr(k, d0, d1, nfr)));
    chk($sformatf("busy k=%0d", k), 32'(bus.stat[5]), 32'(in_frame));
    chk($sformatf("done k=%0d", k), 32'(done), 32'(in_frame && (k % 40 == 0)));
  endtask

  task automatic bus_idle();
    bus.ser_n = 1'b1;
    bus.ba    = '0;
    bus.br_w  = 1'b1;
    bus.bd    = '0;
  endtask

  task automatic bus_raw(input logic ser_n, input logic [9:0] ba,
                         input logic br_w, input logic [7:0] d);
    bus.ser_n = ser_n;
    bus.ba    = ba;
    bus.br_w  = br_w;
    bus.bd    = d;
  endtask

  task automatic bus_wr(input logic [7:0] d);
    bus_raw(1'b0, 10'b01_0000_0010, 1'b0, d);
  endtask

  task automatic bus_rd();
    bus_raw(1'b0, 10'b01_0000_0001, 1'b1, 8'h00);
  endtask

  initial begin
    rst_n = 1'b1;
    bus_idle();
    #2 rst_n = 1'b0;
    #1;
    chk("reset sdwr", 32'(sdwr), 32'd1);
    chk("reset stat", 32'(bus.stat), 32'h00);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame 0xA5 from IDLE
    for (int k = 0; k <= 44; k++) begin
      step_chk(k, 8'hA5, 8'h00, 1);
      if (k == 0) bus_wr(8'hA5);
      else if (k == 1) bus_idle();
      @(negedge clk);
    end

    // 0x3C then 0xC3 during DATA: held until the first stop ends, no gap
    for (int k = 0; k <= 84; k++) begin
      step_chk(k, 8'h3C, 8'hC3, 2);
      chk($sformatf("hold k=%0d", k), 32'(bus.stat[6]), 32'((k >= 9) && (k <= 40)));
      if (k == 0) bus_wr(8'h3C);
      else if (k == 1) bus_idle();
      else if (k == 8) bus_wr(8'hC3);
      else if (k == 9) bus_idle();
      @(negedge clk);
    end

    // Three writes while busy: third is dropped and sets ovr; read clears it
    for (int k = 0; k <= 84; k++) begin
      step_chk(k, 8'h11, 8'h22, 2);
      if (k == 9)  chk("stat before drop", 32'(bus.stat), 32'h60);
      if (k == 12) chk("stat after drop", 32'(bus.stat), 32'hE0);
      if (k == 14) chk("stat after read", 32'(bus.stat), 32'h60);
      if (k == 81) chk("stat after frames", 32'(bus.stat), 32'h00);
      if (k == 0) bus_wr(8'h11);
      else if (k == 1) bus_idle();
      else if (k == 5) bus_wr(8'h22);
      else if (k == 6) bus_idle();
      else if (k == 10) bus_wr(8'h33);
      else if (k == 11) bus_idle();
      else if (k == 13) bus_rd();
      else if (k == 14) bus_idle();
      @(negedge clk);
    end

    // Write decode held for 30 cycles sends exactly one frame
    for (int k = 0; k <= 50; k++) begin
      step_chk(k, 8'h5A, 8'h00, 1);
      chk($sformatf("held hold k=%0d", k), 32'(bus.stat[6]), 32'd0);
      if (k == 0) bus_wr(8'h5A);
      else if (k == 30) bus_idle();
      @(negedge clk);
    end

    // Accesses that miss the window or the data offset do nothing
    for (int t = 0; t < 3; t++) begin
      if (t == 0) bus_raw(1'b0, 10'b00_0000_0010, 1'b0, 8'hFF);
      else if (t == 1) bus_raw(1'b1, 10'b01_0000_0010, 1'b0, 8'hFF);
      else bus_raw(1'b0, 10'b01_0000_0011, 1'b0, 8'hFF);
      @(negedge clk);
      bus_idle();
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("miss%0d sdwr c=%0d", t, c), 32'(sdwr), 32'd1);
        chk($sformatf("miss%0d stat c=%0d", t, c), 32'(bus.stat), 32'h00);
        @(negedge clk);
      end
    end

    // Reset in the middle of a frame, then a clean frame afterwards
    for (int k = 0; k <= 14; k++) begin
      step_chk(k, 8'h96, 8'h00, 1);
      if (k == 0) bus_wr(8'h96);
      else if (k == 1) bus_idle();
      @(negedge clk);
    end
    step_chk(15, 8'h96, 8'h00, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset sdwr", 32'(sdwr), 32'd1);
    chk("midreset stat", 32'(bus.stat), 32'h00);
    chk("midreset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 44; k++) begin
      step_chk(k, 8'h69, 8'h00, 1);
      if (k == 0) bus_wr(8'h69);
      else if (k == 1) bus_idle();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
